// File: rtl/click_rx_sync_pkg.sv
// Shared defaults for the click receive side: data width, sync depth and
// the 2-phase reset value that must agree with click_buf's toggle reset.
package click_rx_sync_pkg;

  localparam int   DEF_DATA_W      = 2;
  localparam int   DEF_SYNC_STAGES = 2;
  localparam int   DEF_FIFO_DEPTH  = 4;
  localparam logic PHASE_RST       = 1'b0;

  // Occupancy needs one bit more than a pointer so "full" is representable.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/click_rx_sync_if.sv
// Click-side token handshake plus the synchronous valid/ready output stream.
// slave = the receiver block, master = whoever drives tokens and consumes data.
interface click_rx_sync_if
  import click_rx_sync_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
);
  localparam int LVL_W = lvl_w(FIFO_DEPTH);

  logic              req_in;
  logic [DATA_W-1:0] data_in;
  logic              ack_out;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_ready;
  logic [LVL_W-1:0]  fifo_level;

  modport slave (
    input  req_in, data_in, m_ready,
    output ack_out, m_valid, m_data, fifo_level
  );

  modport master (
    output req_in, data_in, m_ready,
    input  ack_out, m_valid, m_data, fifo_level
  );
endinterface

// File: rtl/click_rx_sync_sync_ff.sv
// N-stage flop synchroniser for a 2-phase level (req or ack).
// Latency: STAGES clk edges. No backpressure; the input is a free-running level.
// Backpressure: none.
module click_sync_ff
  import click_rx_sync_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {STAGES{PHASE_RST}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/click_rx_sync.sv
// Sink for a 2-phase bundled-data click pipeline: syncs req, buffers tokens, valid/ready out.
// Latency: push and ack toggle SYNC_STAGES+1 edges after a req transition; head shows same cycle.
// Backpressure: ack withheld while the FIFO is full; token pushed on the first edge with space.
module click_rx_sync
  import click_rx_sync_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic            clk,
  input  logic            reset_n,
  click_rx_sync_if.slave  rx
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = lvl_w(FIFO_DEPTH);

  logic              req_s;
  logic              rx_phase_q, rx_phase_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

  logic pending, full, empty, push, pop;

  click_sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (rx.req_in),
    .q_o     (req_s)
  );

  // A token is outstanding whenever the synced req phase differs from the last acked phase.
  assign pending = (req_s != rx_phase_q);
  assign full    = (level_q == LVL_W'(FIFO_DEPTH));
  assign empty   = (level_q == '0);
  assign push    = pending && !full;
  assign pop     = !empty && rx.m_ready;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    rx_phase_d = rx_phase_q;
    if (push) begin
      wr_ptr_d   = wr_ptr_q + 1'b1;
      rx_phase_d = ~rx_phase_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_phase_q <= PHASE_RST;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
    end else begin
      rx_phase_q <= rx_phase_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
    end
  end

  // data_in is bundled: it is stable by the time req_s has crossed, so it is sampled raw.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= rx.data_in;
    end
  end

  assign rx.ack_out    = rx_phase_q;
  assign rx.m_valid    = !empty;
  assign rx.m_data     = mem_q[rd_ptr_q];
  assign rx.fifo_level = level_q;

endmodule

// File: tb/tb_click_rx_sync.sv
// Randomised and directed bench for click_rx_sync against a queue-based token model.
module tb_click_rx_sync;

  localparam int DW    = 2;
  localparam int SYNC  = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  click_rx_sync_if #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) rx_if ();

  click_rx_sync #(
    .DATA_W      (DW),
    .SYNC_STAGES (SYNC),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .rx      (rx_if.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: a queue of accepted tokens plus the one in-flight token.
  logic [DW-1:0] mq [$];
  logic [DW-1:0] popped_q [$];
  bit            m_phase;
  bit            tok_pending;
  int            tok_age;
  logic [DW-1:0] tok_data;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    bit do_pop;
    bit do_push;
    do_pop  = 1'b0;
    do_push = 1'b0;
    if (reset_n) begin
      if (rx_if.m_valid && rx_if.m_ready) popped_q.push_back(rx_if.m_data);
      do_pop = (mq.size() > 0) && rx_if.m_ready;
      if (tok_pending) tok_age++;
      do_push = tok_pending && (tok_age >= SYNC + 1) && (mq.size() < DEPTH);
    end
    @(posedge clk);
    #1;
    if (do_pop) void'(mq.pop_front());
    if (do_push) begin
      mq.push_back(tok_data);
      m_phase     = ~m_phase;
      tok_pending = 1'b0;
    end
    check_eq("ack", int'(rx_if.ack_out), int'(m_phase));
    check_eq("valid", int'(rx_if.m_valid), int'(mq.size() > 0));
    check_eq("level", int'(rx_if.fifo_level), mq.size());
    if (mq.size() > 0) check_eq("head", int'(rx_if.m_data), int'(mq[0]));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [DW-1:0] d);
    int n;
    n = 0;
    while (tok_pending && n < 40) begin
      tick();
      n++;
    end
    check_eq("send_wait", int'(tok_pending), 0);
    if (!tok_pending) begin
      rx_if.data_in = d;
      rx_if.req_in  = ~rx_if.req_in;
      tok_data      = d;
      tok_pending   = 1'b1;
      tok_age       = 0;
    end
  endtask

  task automatic do_reset(input logic req, input logic [DW-1:0] d);
    reset_n = 1'b0;
    #1;
    check_eq("rst_ack", int'(rx_if.ack_out), 0);
    check_eq("rst_valid", int'(rx_if.m_valid), 0);
    check_eq("rst_data", int'(rx_if.m_data), 0);
    check_eq("rst_level", int'(rx_if.fifo_level), 0);
    mq.delete();
    m_phase     = 1'b0;
    tok_pending = 1'b0;
    tok_age     = 0;
    rx_if.req_in  = req;
    rx_if.data_in = d;
    ticks(2);
    reset_n     = 1'b1;
    tok_pending = (req != 1'b0);
    tok_data    = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rx_if.req_in  = 1'b0;
    rx_if.data_in = '0;
    rx_if.m_ready = 1'b0;
    m_phase = 1'b0;
    tok_pending = 1'b0;
    tok_age = 0;
    tok_data = '0;
    @(posedge clk);
    #1;
    do_reset(1'b0, 2'b00);
    ticks(2);

    // Single token: ack exactly three edges after req toggles.
    send(2'b10);
    tick();
    check_eq("single_ack_e0", int'(rx_if.ack_out), 0);
    tick();
    check_eq("single_ack_e1", int'(rx_if.ack_out), 0);
    tick();
    check_eq("single_ack_e2", int'(rx_if.ack_out), 1);
    check_eq("single_data", int'(rx_if.m_data), 2);
    check_eq("single_level", int'(rx_if.fifo_level), 1);

    // Back-pressure: fifth token stays unacked until one pop frees a slot.
    do_reset(1'b0, 2'b00);
    popped_q.delete();
    send(2'b00); send(2'b01); send(2'b10); send(2'b11); send(2'b01);
    ticks(8);
    check_eq("bp_level_full", int'(rx_if.fifo_level), 4);
    check_eq("bp_ack_held", int'(rx_if.ack_out), 0);
    rx_if.m_ready = 1'b1;
    tick();
    rx_if.m_ready = 1'b0;
    check_eq("bp_level_pop", int'(rx_if.fifo_level), 3);
    check_eq("bp_popped_cnt", popped_q.size(), 1);
    if (popped_q.size() > 0) check_eq("bp_popped_val", int'(popped_q[0]), 0);
    tick();
    check_eq("bp_level_refill", int'(rx_if.fifo_level), 4);
    check_eq("bp_ack_late", int'(rx_if.ack_out), 1);
    check_eq("bp_head", int'(rx_if.m_data), 1);

    // Streaming across two pointer wraps.
    do_reset(1'b0, 2'b00);
    popped_q.delete();
    rx_if.m_ready = 1'b1;
    for (int i = 0; i < 10; i++) send(DW'(i % 4));
    ticks(8);
    check_eq("stream_cnt", popped_q.size(), 10);
    for (int i = 0; i < popped_q.size(); i++) check_eq("stream_order", int'(popped_q[i]), i % 4);
    rx_if.m_ready = 1'b0;

    // Push and pop on the same edge at level 2.
    do_reset(1'b0, 2'b00);
    send(2'b10); send(2'b01); send(2'b11);
    ticks(2);
    check_eq("sim_pre_level", int'(rx_if.fifo_level), 2);
    rx_if.m_ready = 1'b1;
    tick();
    rx_if.m_ready = 1'b0;
    check_eq("sim_level", int'(rx_if.fifo_level), 2);
    check_eq("sim_head", int'(rx_if.m_data), 1);
    check_eq("sim_ack", int'(rx_if.ack_out), 1);

    // Random traffic with shifting consumer pressure.
    for (int blk = 0; blk < 8; blk++) begin
      int pct;
      pct = $urandom_range(5, 95);
      for (int i = 0; i < 50; i++) begin
        rx_if.m_ready = ($urandom_range(0, 99) < pct);
        if (!tok_pending && $urandom_range(0, 2) == 0) send(DW'($urandom_range(0, 3)));
        tick();
      end
    end

    // Mid-stream reset, released with req_in high: treated as a fresh token.
    rx_if.m_ready = 1'b0;
    do_reset(1'b1, 2'b11);
    tick();
    tick();
    check_eq("rstreq_ack_early", int'(rx_if.ack_out), 0);
    tick();
    check_eq("rstreq_ack", int'(rx_if.ack_out), 1);
    check_eq("rstreq_data", int'(rx_if.m_data), 3);
    check_eq("rstreq_valid", int'(rx_if.m_valid), 1);

    // m_ready with an empty FIFO must not move anything.
    rx_if.m_ready = 1'b1;
    ticks(3);
    check_eq("empty_level", int'(rx_if.fifo_level), 0);
    rx_if.m_ready = 1'b0;
    send(2'b01);
    ticks(3);
    check_eq("empty_after_data", int'(rx_if.m_data), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
